spi2adc: RTL and testbench
==========================

Name: spi2adc

Overview:
- SPI initiator that reads one 10-bit conversion from the board's MCP3002-style 2-channel ADC per start request.
- It is the capture-side counterpart of the DAC output path: the sample tick launches a frame, the block drives CS/SCK/SDI, and it shifts the conversion in from ADC_SDO.
- It presents data_out with a one-cycle data_valid pulse, ready for the ROM/PWM/DAC processing chain.

Parameters:
- SCK_HALF, 25, CLOCK_50 cycles per SCK half-period (legal range ≥2). The default gives 1 MHz SCK from 50 MHz.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request, normally the 10 kHz sample tick.
- channel  input  1  ADC channel select (0 = CH0, 1 = CH1), latched at accepted start.
- ADC_SDO  input  1  serial data from ADC (MISO).
- ADC_CS  output  1  active-low chip select.
- ADC_SCK  output  1  serial clock, idle low (mode 0,0).
- ADC_SDI  output  1  serial command to ADC (MOSI).
- data_out  output  10  last completed conversion, unsigned.
- data_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, RESET_N=0) forces the following, immediately and also mid-frame:
  - ADC_CS=1, ADC_SCK=0, ADC_SDI=0
  - data_out=0, data_valid=0, busy=0
  - state=IDLE, all counters cleared
- The partial frame is discarded; no data_valid follows.
- States:
  - IDLE: CS high, SCK low.
  - SHIFT: 16 SCK cycles.
  - DONE: single cycle.
- IDLE -> SHIFT:
  - Triggered by start=1 sampled at edge T.
  - At T+1: CS=0, busy=1, channel latched, SDI=slot0, divider count=0, bit index=0.
  - A start in any state other than IDLE is ignored. It is not queued.
- SCK timing:
  - Divider counts 0..SCK_HALF-1; SCK toggles at each wrap.
  - Rising edge k (k=0..15) at T+1+(2k+1)*SCK_HALF.
  - Falling edge k at T+1+(2k+2)*SCK_HALF.
- SDI slots 0..15, each driven from CS-low (slot0) or from the preceding falling edge:
  - slot0 = 0 (pad)
  - slot1 = 1 (start)
  - slot2 = 1 (SGL)
  - slot3 = latched channel
  - slot4 = 1 (MSBF)
  - slots 5..15 = 0
- Capture:
  - ADC_SDO is sampled on the CLOCK_50 edge that drives SCK high, for rising edges 6..15.
  - These bits are D9..D0, MSB first, shifted into a 10-bit register.
  - Edges 0..5 (including the ADC null bit at edge 5) are not captured.
- Falling edge 15 (T+1+32*SCK_HALF):
  - Enters DONE: CS=1, SCK=0, SDI=0.
  - data_out takes the shift register; data_valid=1 for exactly this cycle.
  - busy stays 1 in DONE.
- The next edge returns to IDLE: busy=0, data_valid=0.
- Latency:
  - Default start-to-data_valid is 1+32*25 = 801 cycles.
  - The earliest accepted restart is start at T+802, so a frame fits well inside the 5000-cycle tick period.
- Boundary and invariant rules:
  - A start coincident with DONE is ignored.
  - A change on channel mid-frame has no effect.
  - data_out holds its value between frames.
  - SCK never toggles while CS=1.
  - Bit index and divider are sized from SCK_HALF and 16; no wrap beyond slot15.

Test Plan:
- Reset, start at T with channel=0; ADC model returns 10'h2A5 -> ADC_SDI slots = 0,1,1,0,1,0×11; data_out=10'h2A5; data_valid high only at T+801; CS low T+1..T+800.
- channel=1, model returns 10'h3FF then 10'h000 on two ticks 5000 apart -> slot3=1; data_out=10'h3FF then 10'h000; exactly two data_valid pulses.
- start pulses at T+100 and T+801 during a frame -> ignored, single frame, busy continuous T+1..T+801.
- RESET_N low at T+400 mid-frame -> CS=1, SCK=0, data_out=0 immediately; no data_valid; next start runs a clean frame.
- SCK_HALF=2, model value 10'h155 -> 16 SCK periods of 4 cycles; data_valid at T+65; data_out=10'h155.
- channel toggled at T+50 with latched channel=0 -> slot3 remains 0; capture unaffected.

Source files
------------

// File: rtl/spi2adc.sv
// SPI initiator for an MCP3002-style ADC.
// Each accepted start runs one 16-SCK frame and returns a 10-bit sample.
module spi2adc #(
  parameter int SCK_HALF = 25
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       channel,
  input  logic       ADC_SDO,
  output logic       ADC_CS,
  output logic       ADC_SCK,
  output logic       ADC_SDI,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int DW = $clog2(SCK_HALF);
  localparam logic [DW-1:0] HMAX = DW'(SCK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            sdi_q, sdi_d;
  logic            ch_q, ch_d;
  logic [9:0]      sh_q, sh_d;
  logic [9:0]      dout_q, dout_d;
  logic            wrap;

  // Command: pad, start, SGL, channel, MSBF, then zeros.
  function automatic logic slot(
    input logic [3:0] idx,
    input logic       ch
  );
    logic s;
    s = 1'b0;
    unique case (1'b1)
      idx == 4'd1,
      idx == 4'd2,
      idx == 4'd4: s = 1'b1;
      idx == 4'd3: s = ch;
      default:     s = 1'b0;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      ch_q    <= 1'b0;
      sh_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
      ch_q    <= ch_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
    end
  end

  assign wrap = (div_q == HMAX);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    ch_d    = ch_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          sdi_d   = 1'b0;
          ch_d    = channel;
          sh_d    = '0;
        end
      end
      SHIFT: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
          if (!sck_q) begin
            sck_d = 1'b1;
            // Edges 0..5 carry command and null bit.
            if (bit_q >= 4'd6)
              sh_d = {sh_q[8:0], ADC_SDO};
          end else if (bit_q == 4'd15) begin
            state_d = DONE;
            sck_d   = 1'b0;
            sdi_d   = 1'b0;
            dout_d  = sh_q;
          end else begin
            sck_d = 1'b0;
            bit_d = bit_q + 4'd1;
            sdi_d = slot(bit_q + 4'd1, ch_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ADC_CS     = (state_q != SHIFT);
  assign ADC_SCK    = sck_q;
  assign ADC_SDI    = sdi_q;
  assign data_out   = dout_q;
  assign data_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi2adc.sv
// Scoreboard bench for spi2adc with a behavioural ADC model.
// A second instance exercises the minimum SCK half-period.
module tb_spi2adc;

  logic       clk;
  logic       rst_n;
  logic       start1, ch1, sdo1, cs1, sck1, sdi1, dv1, busy1;
  logic [9:0] dout1;
  logic       start2, sdo2, cs2, sck2, sdi2, dv2, busy2;
  logic [9:0] dout2;

  spi2adc #(.SCK_HALF(25)) u_dut1 (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .start      (start1),
    .channel    (ch1),
    .ADC_SDO    (sdo1),
    .ADC_CS     (cs1),
    .ADC_SCK    (sck1),
    .ADC_SDI    (sdi1),
    .data_out   (dout1),
    .data_valid (dv1),
    .busy       (busy1)
  );

  spi2adc #(.SCK_HALF(2)) u_dut2 (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .start      (start2),
    .channel    (1'b0),
    .ADC_SDO    (sdo2),
    .ADC_CS     (cs2),
    .ADC_SCK    (sck2),
    .ADC_SDI    (sdi2),
    .data_out   (dout2),
    .data_valid (dv2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: SDO presents the bit for the next rising SCK edge.
  logic [9:0]  val1, val2;
  int          r1 = 0, r2 = 0;
  logic [15:0] cap1, cap2;

  always @(posedge cs1) r1 = 0;
  always @(posedge sck1) begin
    cap1 = {cap1[14:0], sdi1};
    r1   = r1 + 1;
  end
  always @(posedge cs2) r2 = 0;
  always @(posedge sck2) begin
    cap2 = {cap2[14:0], sdi2};
    r2   = r2 + 1;
  end
  assign sdo1 = (r1 >= 6 && r1 <= 15) ? val1[15-r1] : 1'b0;
  assign sdo2 = (r2 >= 6 && r2 <= 15) ? val2[15-r2] : 1'b0;

  typedef struct {
    logic [9:0]  data;
    logic [15:0] cmd;
    int          ts;
  } exp_t;

  exp_t q[$];
  int   ncs = 0, nbz = 0, ndv1 = 0, sck_bad = 0;
  int   ts2 = 0, seen2 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cs1 && sck1) sck_bad++;
      if (cs2 && sck2) sck_bad++;
      if (!cs1) ncs++;
      if (busy1) nbz++;
      if (dv1) begin
        ndv1++;
        if (q.size() == 0) begin
          chk("unexpected_dv", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_out", 32'(dout1), 32'(e.data));
          chk("sdi_cmd", 32'(cap1), 32'(e.cmd));
          chk("latency", 32'(cyc - e.ts), 801);
          chk("cs_low_cycles", 32'(ncs), 800);
          chk("busy_cycles", 32'(nbz), 801);
        end
        ncs = 0;
        nbz = 0;
      end
      if (dv2) begin
        seen2++;
        chk("h2_data_out", 32'(dout2), 32'h155);
        chk("h2_sdi_cmd", 32'(cap2), 32'h6800);
        chk("h2_latency", 32'(cyc - ts2), 65);
      end
    end
  end

  function automatic logic [15:0] cmd_of(input logic c);
    return c ? 16'h7800 : 16'h6800;
  endfunction

  task automatic launch(input logic c, input logic [9:0] v,
                        output int ts);
    exp_t e;
    @(negedge clk);
    ch1    = c;
    val1   = v;
    start1 = 1'b1;
    ts     = cyc;
    e.data = v;
    e.cmd  = cmd_of(c);
    e.ts   = ts;
    q.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_dv1(input int lim);
    int n;
    n = 0;
    while (!dv1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!dv1) chk("dv_timeout", 0, 1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int ts;

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    ch1    = 1'b0;
    val1   = '0;
    val2   = '0;
    cap1   = '0;
    cap2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs1), 1);
    chk("rst_sck", 32'(sck1), 0);
    chk("rst_sdi", 32'(sdi1), 0);
    chk("rst_dout", 32'(dout1), 0);
    chk("rst_dv", 32'(dv1), 0);
    chk("rst_busy", 32'(busy1), 0);
    rst_n = 1'b1;

    // Fast instance at minimum half-period.
    @(negedge clk);
    val2   = 10'h155;
    start2 = 1'b1;
    ts2    = cyc;
    @(negedge clk);
    start2 = 1'b0;
    repeat (80) @(negedge clk);
    chk("h2_frames", 32'(seen2), 1);

    // Channel 0 basic frame.
    launch(1'b0, 10'h2A5, ts);
    wait_dv1(900);
    @(negedge clk);

    // Two ticks 5000 apart on channel 1.
    launch(1'b1, 10'h3FF, ts);
    wait_dv1(900);
    wait_until(ts + 5000);
    launch(1'b1, 10'h000, ts);
    wait_dv1(900);
    @(negedge clk);

    // Starts during a frame and coincident with DONE are dropped.
    launch(1'b0, 10'h1C3, ts);
    wait_until(ts + 100);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_dv1(900);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_start_ignored", 32'(busy1), 0);
    chk("hold_dout", 32'(dout1), 32'h1C3);

    // Reset in the middle of a frame.
    launch(1'b1, 10'h2DB, ts);
    wait_until(ts + 400);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs1), 1);
    chk("midrst_sck", 32'(sck1), 0);
    chk("midrst_dout", 32'(dout1), 0);
    chk("midrst_busy", 32'(busy1), 0);
    q.delete();
    ncs = 0;
    nbz = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (900) @(negedge clk);

    // Channel change mid-frame does not reach slot 3.
    launch(1'b0, 10'h0F0, ts);
    wait_until(ts + 50);
    ch1 = 1'b1;
    wait_dv1(900);
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 0);
    chk("dv_total", 32'(ndv1), 5);
    chk("sck_idle_cs_high", 32'(sck_bad), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
